// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard logic.
// Stall depths are the bubble counts each hazard class needs before ID can proceed.
package pipe_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   localparam logic [1:0] LOAD_USE_STALL    = 2'd1;
   localparam logic [1:0] BR_ALU_STALL      = 2'd1;
   localparam logic [1:0] BR_LOAD_EX_STALL  = 2'd2;
   localparam logic [1:0] BR_LOAD_MEM_STALL = 2'd1;

   function automatic logic [1:0] depth_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_compare.sv
// Compares the ID source registers against one downstream stage's destination.
// matchLoad marks a match whose producer is a load (value not ready until after MEM).
module hazard_compare (
   input  logic       useRs,
   input  logic       useRt,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       RegWrite,
   input  logic       MemRead,
   input  logic [4:0] WriteReg,
   output logic       match,
   output logic       matchLoad
);

   logic dest_valid;
   logic rs_hit;
   logic rt_hit;

   // $0 is hard-wired zero, so writes to it never produce a dependency.
   assign dest_valid = RegWrite && (WriteReg != 5'd0);
   assign rs_hit     = useRs && (rs == WriteReg);
   assign rt_hit     = useRt && (rt == WriteReg);
   assign match      = dest_valid && (rs_hit || rt_hit);
   assign matchLoad  = match && MemRead;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: bubbles ID/EX, freezes PC and IF/ID, flushes IF/ID on taken
// branches, holds two-cycle stalls in a small FSM, and counts stall/flush cycles.
module hazard_stall_unit
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [4:0]       rs_ID,
   input  logic [4:0]       rt_ID,
   input  logic             useRs_ID,
   input  logic             useRt_ID,
   input  logic             branch_ID,
   input  logic             takeBranch_ID,
   input  logic             RegWrite_EX,
   input  logic             MemRead_EX,
   input  logic [4:0]       WriteReg_EX,
   input  logic             RegWrite_MEM,
   input  logic             MemRead_MEM,
   input  logic [4:0]       WriteReg_MEM,
   output logic             noOp,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic ex_match, ex_match_load, mem_match, mem_match_load;
   logic [1:0] depth;
   logic stall;

   state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   hazard_compare u_cmp_ex (
      .useRs     (useRs_ID),
      .useRt     (useRt_ID),
      .rs        (rs_ID),
      .rt        (rt_ID),
      .RegWrite  (RegWrite_EX),
      .MemRead   (MemRead_EX),
      .WriteReg  (WriteReg_EX),
      .match     (ex_match),
      .matchLoad (ex_match_load)
   );

   hazard_compare u_cmp_mem (
      .useRs     (useRs_ID),
      .useRt     (useRt_ID),
      .rs        (rs_ID),
      .rt        (rt_ID),
      .RegWrite  (RegWrite_MEM),
      .MemRead   (MemRead_MEM),
      .WriteReg  (WriteReg_MEM),
      .match     (mem_match),
      .matchLoad (mem_match_load)
   );

   // Non-branch consumers get the MEM result forwarded, so only branches care about MEM.
   always_comb begin
      depth = 2'd0;
      if (ex_match_load)
         depth = depth_max(depth, LOAD_USE_STALL);
      if (branch_ID && ex_match && !MemRead_EX)
         depth = depth_max(depth, BR_ALU_STALL);
      if (branch_ID && ex_match_load)
         depth = depth_max(depth, BR_LOAD_EX_STALL);
      if (branch_ID && mem_match_load)
         depth = depth_max(depth, BR_LOAD_MEM_STALL);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (depth != 2'd0) begin
               stall = 1'b1;
               // Single-cycle stalls stay in RUN and simply re-evaluate next cycle.
               if (depth >= 2'd2) begin
                  state_d = ST_STALL;
                  cnt_d   = depth - 2'd1;
               end
            end
         end
         ST_STALL: begin
            stall = 1'b1;
            if (cnt_q <= 2'd1) begin
               state_d = ST_RUN;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (IFIDFlush && (flush_cnt_q != CNT_MAX))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Reset forces a frozen pipeline regardless of the FSM.
   assign noOp        = stall || !Rst_n;
   assign PCWrite     = !noOp;
   assign IFIDWrite   = !noOp;
   assign IFIDFlush   = takeBranch_ID && !stall && Rst_n;
   assign stallCycles = stall_cnt_q;
   assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with 4-bit counters so saturation is reachable.
module tb_hazard_stall_unit;

   localparam int CNT_W = 4;

   logic             Clk = 1'b0;
   logic             Rst_n;
   logic [4:0]       rs_ID, rt_ID, WriteReg_EX, WriteReg_MEM;
   logic             useRs_ID, useRt_ID, branch_ID, takeBranch_ID;
   logic             RegWrite_EX, MemRead_EX, RegWrite_MEM, MemRead_MEM;
   logic             noOp, PCWrite, IFIDWrite, IFIDFlush;
   logic [CNT_W-1:0] stallCycles, flushCount;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   hazard_stall_unit #(.CNT_W(CNT_W)) dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .rs_ID         (rs_ID),
      .rt_ID         (rt_ID),
      .useRs_ID      (useRs_ID),
      .useRt_ID      (useRt_ID),
      .branch_ID     (branch_ID),
      .takeBranch_ID (takeBranch_ID),
      .RegWrite_EX   (RegWrite_EX),
      .MemRead_EX    (MemRead_EX),
      .WriteReg_EX   (WriteReg_EX),
      .RegWrite_MEM  (RegWrite_MEM),
      .MemRead_MEM   (MemRead_MEM),
      .WriteReg_MEM  (WriteReg_MEM),
      .noOp          (noOp),
      .PCWrite       (PCWrite),
      .IFIDWrite     (IFIDWrite),
      .IFIDFlush     (IFIDFlush),
      .stallCycles   (stallCycles),
      .flushCount    (flushCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic idle();
      rs_ID = 5'd0; rt_ID = 5'd0; useRs_ID = 1'b0; useRt_ID = 1'b0;
      branch_ID = 1'b0; takeBranch_ID = 1'b0;
      RegWrite_EX = 1'b0; MemRead_EX = 1'b0; WriteReg_EX = 5'd0;
      RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0; WriteReg_MEM = 5'd0;
   endtask

   // Advance to just after the next rising edge; inputs are then changed mid-cycle.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_run(input string tag);
      chk({tag, ".noOp"}, 32'(noOp), 32'd0);
      chk({tag, ".PCWrite"}, 32'(PCWrite), 32'd1);
      chk({tag, ".IFIDWrite"}, 32'(IFIDWrite), 32'd1);
   endtask

   task automatic chk_stall(input string tag);
      chk({tag, ".noOp"}, 32'(noOp), 32'd1);
      chk({tag, ".PCWrite"}, 32'(PCWrite), 32'd0);
      chk({tag, ".IFIDWrite"}, 32'(IFIDWrite), 32'd0);
   endtask

   initial begin
      idle();
      Rst_n = 1'b1;
      #3 Rst_n = 1'b0;
      #1;
      chk_stall("rst");
      chk("rst.IFIDFlush", 32'(IFIDFlush), 32'd0);
      chk("rst.stallCycles", 32'(stallCycles), 32'd0);
      chk("rst.flushCount", 32'(flushCount), 32'd0);
      tick();
      Rst_n = 1'b1;
      #1 chk_run("post_rst");

      // Load-use: lw $2 in EX, add using rs=2 in ID
      tick();
      RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteReg_EX = 5'd2;
      rs_ID = 5'd2; useRs_ID = 1'b1;
      #1 chk_stall("lduse.c0");
      chk("lduse.cnt0", 32'(stallCycles), 32'd0);
      tick();
      // Load moved to MEM, bubble in EX; a non-branch consumer is forwarded
      RegWrite_EX = 1'b0; MemRead_EX = 1'b0; WriteReg_EX = 5'd0;
      RegWrite_MEM = 1'b1; MemRead_MEM = 1'b1; WriteReg_MEM = 5'd2;
      #1 chk_run("lduse.c1");
      chk("lduse.cnt1", 32'(stallCycles), 32'd1);

      // Branch after load in EX: beq reads rt=5, lw $5 in EX -> two stall cycles
      tick();
      idle();
      branch_ID = 1'b1; rt_ID = 5'd5; useRt_ID = 1'b1;
      RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteReg_EX = 5'd5;
      #1 chk_stall("brldex.c0");
      tick();
      RegWrite_EX = 1'b0; MemRead_EX = 1'b0; WriteReg_EX = 5'd0;
      #1 chk_stall("brldex.c1");
      chk("brldex.cnt1", 32'(stallCycles), 32'd2);
      tick();
      idle();
      #1 chk_run("brldex.c2");
      chk("brldex.cnt2", 32'(stallCycles), 32'd3);

      // Register $0 never hazards
      idle();
      RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteReg_EX = 5'd0;
      rs_ID = 5'd0; useRs_ID = 1'b1;
      #1 chk_run("reg0");

      // Branch after ALU op in EX: one stall
      tick();
      idle();
      branch_ID = 1'b1; rs_ID = 5'd7; useRs_ID = 1'b1;
      RegWrite_EX = 1'b1; WriteReg_EX = 5'd7;
      #1 chk_stall("bralu.c0");
      tick();
      idle();
      #1 chk_run("bralu.c1");
      chk("bralu.cnt", 32'(stallCycles), 32'd4);

      // Branch after load in MEM: one stall; non-branch with same MEM load: none
      branch_ID = 1'b1; rt_ID = 5'd9; useRt_ID = 1'b1;
      RegWrite_MEM = 1'b1; MemRead_MEM = 1'b1; WriteReg_MEM = 5'd9;
      #1 chk_stall("brldmem.c0");
      tick();
      branch_ID = 1'b0;
      #1 chk_run("ldmem_nobr");
      chk("brldmem.cnt", 32'(stallCycles), 32'd5);

      // Use flag clear: matching register numbers but not read
      idle();
      RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteReg_EX = 5'd4;
      rs_ID = 5'd4; useRs_ID = 1'b0;
      #1 chk_run("nouse");

      // Flush without hazard
      tick();
      idle();
      takeBranch_ID = 1'b1;
      #1 chk("flush.IFIDFlush", 32'(IFIDFlush), 32'd1);
      chk("flush.noOp", 32'(noOp), 32'd0);
      tick();
      // Taken branch together with a load-use hazard: the stall wins
      RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteReg_EX = 5'd3;
      rs_ID = 5'd3; useRs_ID = 1'b1;
      #1 chk("flush.cnt1", 32'(flushCount), 32'd1);
      chk("flushstall.IFIDFlush", 32'(IFIDFlush), 32'd0);
      chk("flushstall.noOp", 32'(noOp), 32'd1);
      tick();
      idle();
      #1 chk("flushstall.flushCount", 32'(flushCount), 32'd1);
      chk("flushstall.stallCycles", 32'(stallCycles), 32'd6);

      // Reset during the first cycle of a D=2 stall
      branch_ID = 1'b1; rt_ID = 5'd6; useRt_ID = 1'b1;
      RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteReg_EX = 5'd6;
      #1 chk_stall("rstmid.pre");
      Rst_n = 1'b0;
      #1 chk_stall("rstmid.in");
      chk("rstmid.stallCycles", 32'(stallCycles), 32'd0);
      chk("rstmid.flushCount", 32'(flushCount), 32'd0);
      idle();
      tick();
      Rst_n = 1'b1;
      #1 chk_run("rstmid.rel0");
      chk("rstmid.rel.stallCycles", 32'(stallCycles), 32'd0);
      chk("rstmid.rel.flushCount", 32'(flushCount), 32'd0);
      tick();
      #1 chk_run("rstmid.rel1");
      chk("rstmid.rel1.stallCycles", 32'(stallCycles), 32'd0);

      // Saturation: 20 consecutive load-use stall cycles, 4-bit counter stops at 15
      RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteReg_EX = 5'd8;
      rt_ID = 5'd8; useRt_ID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (i == 0 || i == 19) chk("sat.noOp", 32'(noOp), 32'd1);
         if (i == 15) chk("sat.at15", 32'(stallCycles), 32'd15);
         tick();
      end
      idle();
      #1 chk("sat.stallCycles", 32'(stallCycles), 32'd15);
      chk_run("sat.end");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 5-stage MIPS core. It sits in the ID stage directly upstream of the control bubble mux and drives its `noOp` input. It also gates PC and IF/ID register writes and flushes IF/ID on taken branches and jumps. A small FSM with a stall-depth counter holds multi-cycle stalls for branches resolved in ID, and two saturating counters record stall and flush events for performance tracking.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `Clk` input 1: pipeline clock, rising edge.
- `Rst_n` input 1: reset, asynchronous, active-low.
- `rs_ID`, `rt_ID` input 5 each: source register fields in ID.
- `useRs_ID`, `useRt_ID` input 1 each: the ID instruction reads rs / rt.
- `branch_ID` input 1: ID instruction is a branch compared in ID, or `jr`.
- `takeBranch_ID` input 1: ID resolved a taken branch or jump this cycle.
- `RegWrite_EX`, `MemRead_EX` input 1 each: EX-stage control.
- `WriteReg_EX` input 5: EX destination register.
- `RegWrite_MEM`, `MemRead_MEM` input 1 each: MEM-stage control.
- `WriteReg_MEM` input 5: MEM destination register.
- `noOp` output 1: to the control bubble mux; 1 inserts a bubble into ID/EX.
- `PCWrite` output 1: PC register write enable.
- `IFIDWrite` output 1: IF/ID register write enable.
- `IFIDFlush` output 1: zero the IF/ID register on the next edge.
- `stallCycles` output CNT_W: count of cycles with `noOp`=1, saturating.
- `flushCount` output CNT_W: count of cycles with `IFIDFlush`=1, saturating.

## Operation
- Match rule: a source matches a destination when its use flag = 1, the writer's RegWrite = 1, the register numbers are equal, and the destination ≠ 0. Register $0 never creates a hazard.
- The required stall depth D is computed in RUN. It is the maximum of the following:
  - Load-use: `MemRead_EX` with a match on rs or rt: D=1.
  - Branch after ALU op: `branch_ID` with an EX match where `MemRead_EX`=0: D=1.
  - Branch after load in EX: `branch_ID` with an EX match where `MemRead_EX`=1: D=2.
  - Branch after load in MEM: `branch_ID` with a MEM match where `MemRead_MEM`=1: D=1.
  - No hazard: D=0.
- The FSM has two states: RUN and STALL.
  - RUN with D=0: `noOp`=0, `PCWrite`=1, `IFIDWrite`=1.
  - RUN with D≥1: stall asserted combinationally in the same cycle (`noOp`=1, `PCWrite`=0, `IFIDWrite`=0). Next state is STALL with `cnt`=D−1 if D=2; otherwise stay in RUN. A D=1 stall re-evaluates naturally on the next cycle.
  - STALL: stall asserted unconditionally, hazard inputs ignored. Decrement `cnt`; return to RUN when `cnt`=0 at the edge.
- Flush: `IFIDFlush` = `takeBranch_ID` AND no stall this cycle. When a stall and a taken branch occur together, the stall wins and no flush is issued; the branch re-resolves after the stall.
- Counters increment by 1 per qualifying cycle and hold at 2^CNT_W−1.

## Timing
- While `Rst_n`=0: state=RUN, `cnt`=0, counters=0. Outputs are forced to `noOp`=1, `PCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=0.
- Reset asserted mid-stall aborts the stall immediately. After release the unit starts in RUN, and the counters restart from 0.
- Outputs in RUN are Mealy (combinational from the current inputs). Outputs in STALL depend only on state.
- Stall lengths: D=1 gives 1 stall cycle; D=2 gives exactly 2 consecutive stall cycles.
- Counters update on the rising edge after the qualifying cycle.

## Structure
- Shared package `pipe_pkg`:
  - State encoding: `ST_RUN`, `ST_STALL`.
  - Stall-depth constants: `LOAD_USE_STALL`=1, `BR_ALU_STALL`=1, `BR_LOAD_EX_STALL`=2, `BR_LOAD_MEM_STALL`=1.
- Sub-module `hazard_compare`: purely combinational. It takes the rs/rt, use flags, and one stage's RegWrite, MemRead and WriteReg, and returns `match` and `matchLoad`. It is instanced once for EX and once for MEM.

## Test plan
- Load-use: `lw $2` in EX (`MemRead_EX`=1, `WriteReg_EX`=2), `add` in ID with rs=2 -> `noOp`=1, `PCWrite`=0, `IFIDWrite`=0 for exactly 1 cycle; `stallCycles` goes 0→1.
- Branch after load in EX: `beq` in ID with rt=5, load in EX writing $5 -> 2 consecutive stall cycles. EX-stage inputs changing during the second cycle have no effect.
- Register $0: `MemRead_EX`=1, `WriteReg_EX`=0, rs_ID=0 with `useRs_ID`=1 -> no stall.
- Flush vs stall: `takeBranch_ID`=1 with no hazard -> `IFIDFlush`=1, `flushCount`++. The same together with a D=1 hazard -> `IFIDFlush`=0, `noOp`=1.
- Reset mid-stall: drive `Rst_n` low during the first cycle of a D=2 stall -> outputs immediately read `noOp`=1, `PCWrite`=0. After release with no hazard: `noOp`=0, `PCWrite`=1, counters=0.
- Saturation: CNT_W=4, hold a stall for 20 cycles via repeated hazards -> `stallCycles` stops at 15.
